// File: rtl/sweep_pkg.sv
// Shared types and default widths for the impedance-analyzer frequency sweep sequencer.
package sweep_pkg;

  localparam int unsigned FTW_W       = 32;
  localparam int unsigned PT_W        = 12;
  localparam int unsigned CNT_W       = 24;
  localparam int unsigned TIMEOUT_CYC = 4800000;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StMeasure,
    StStep,
    StDone
  } sweep_state_e;

endpackage

// File: rtl/sweep_sequencer_if.sv
// Control/config/status bundle between the sweep sequencer and its host/acquisition side.
interface sweep_sequencer_if;
  import sweep_pkg::*;

  logic             Start;
  logic             Abort;
  logic [FTW_W-1:0] Cfg_FtwStart;
  logic [FTW_W-1:0] Cfg_FtwStep;
  logic [PT_W-1:0]  Cfg_NPoints;
  logic [CNT_W-1:0] Cfg_Settle;
  logic             Meas_Done;
  logic [FTW_W-1:0] Ftw;
  logic             Ftw_Valid;
  logic             Dac_En;
  logic             Meas_Req;
  logic [PT_W-1:0]  Point_Idx;
  logic             Busy;
  logic             Sweep_Done;
  logic             Timeout_Err;

  modport master (
    output Start, Abort, Cfg_FtwStart, Cfg_FtwStep, Cfg_NPoints, Cfg_Settle, Meas_Done,
    input  Ftw, Ftw_Valid, Dac_En, Meas_Req, Point_Idx, Busy, Sweep_Done, Timeout_Err
  );

  modport slave (
    input  Start, Abort, Cfg_FtwStart, Cfg_FtwStep, Cfg_NPoints, Cfg_Settle, Meas_Done,
    output Ftw, Ftw_Valid, Dac_En, Meas_Req, Point_Idx, Busy, Sweep_Done, Timeout_Err
  );

endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter; expired while the count sits at zero, counting stops there.
module settle_timer #(
  parameter int unsigned Width = 24
) (
  input  logic             Pll_CLK,
  input  logic             RESETn,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_count,
  output logic             o_expired
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge Pll_CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - Width'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/sweep_sequencer.sv
// Frequency-sweep controller: steps the tuning word, gates the DAC, handshakes measurements.
// Optional measurement timeout enabled by defining SWEEP_TIMEOUT_EN.
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int unsigned TimeoutCyc = TIMEOUT_CYC
)
(
  input logic              Pll_CLK,
  input logic              RESETn,
  sweep_sequencer_if.slave bus
);

  sweep_state_e r_state, w_state_nxt;

  logic [FTW_W-1:0] r_ftw_start, r_ftw_step, r_ftw, w_ftw_nxt;
  logic [PT_W-1:0]  r_npoints, r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_settle, w_settle_val;
  logic r_ftw_valid, w_ftw_valid_nxt;
  logic r_dac_en, w_dac_en_nxt;
  logic r_meas_req, w_meas_req_nxt;
  logic r_sweep_done, w_sweep_done_nxt;
  logic r_timeout_err, w_timeout_err_nxt;
  logic w_settle_exp, w_to_hit, w_accept;

  assign w_accept = (r_state == StIdle) && bus.Start && !bus.Abort;

  always_ff @(posedge Pll_CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_ftw_start <= '0;
      r_ftw_step  <= '0;
      r_npoints   <= '0;
      r_settle    <= '0;
    end else if (w_accept) begin
      r_ftw_start <= bus.Cfg_FtwStart;
      r_ftw_step  <= bus.Cfg_FtwStep;
      r_npoints   <= bus.Cfg_NPoints;
      r_settle    <= bus.Cfg_Settle;
    end
  end

  // Loading S-1 makes SETTLE last max(Cfg_Settle,1) cycles.
  assign w_settle_val = (r_settle == '0) ? '0 : r_settle - CNT_W'(1);

  settle_timer #(.Width(CNT_W)) u_settle (
    .Pll_CLK    (Pll_CLK),
    .RESETn     (RESETn),
    .i_load     ((r_state == StLoad) || (r_state == StStep)),
    .i_load_val (w_settle_val),
    .i_count    (r_state == StSettle),
    .o_expired  (w_settle_exp)
  );

`ifdef SWEEP_TIMEOUT_EN
  logic w_to_exp;

  settle_timer #(.Width(CNT_W)) u_timeout (
    .Pll_CLK    (Pll_CLK),
    .RESETn     (RESETn),
    .i_load     ((r_state == StSettle) && w_settle_exp),
    .i_load_val (CNT_W'(TimeoutCyc - 1)),
    .i_count    (r_state == StMeasure),
    .o_expired  (w_to_exp)
  );

  // A Meas_Done on the final allowed cycle still counts as a completed measurement.
  assign w_to_hit = (r_state == StMeasure) && w_to_exp && !bus.Meas_Done;
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge Pll_CLK or negedge RESETn) begin
    if (!RESETn) r_state <= StIdle;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.Abort) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle:    if (bus.Start) w_state_nxt = (bus.Cfg_NPoints == '0) ? StDone : StLoad;
        StLoad:    w_state_nxt = StSettle;
        StSettle:  if (w_settle_exp) w_state_nxt = StMeasure;
        StMeasure: begin
          if (bus.Meas_Done) begin
            w_state_nxt = (r_idx == r_npoints - PT_W'(1)) ? StDone : StStep;
          end else if (w_to_hit) begin
            w_state_nxt = StIdle;
          end
        end
        StStep:    w_state_nxt = StSettle;
        StDone:    w_state_nxt = StIdle;
        default:   w_state_nxt = StIdle;
      endcase
    end
  end

  always_comb begin
    w_ftw_nxt         = r_ftw;
    w_idx_nxt         = r_idx;
    w_ftw_valid_nxt   = 1'b0;
    w_dac_en_nxt      = r_dac_en;
    w_meas_req_nxt    = 1'b0;
    w_sweep_done_nxt  = 1'b0;
    w_timeout_err_nxt = r_timeout_err;
    if (bus.Abort) begin
      w_dac_en_nxt = 1'b0;
    end else begin
      unique case (r_state)
        StIdle:   if (bus.Start) w_timeout_err_nxt = 1'b0;
        StLoad: begin
          w_ftw_nxt       = r_ftw_start;
          w_idx_nxt       = '0;
          w_ftw_valid_nxt = 1'b1;
          w_dac_en_nxt    = 1'b1;
        end
        StSettle: w_meas_req_nxt = w_settle_exp;
        StMeasure: begin
          w_meas_req_nxt = !bus.Meas_Done && !w_to_hit;
          if (w_to_hit) begin
            w_timeout_err_nxt = 1'b1;
            w_dac_en_nxt      = 1'b0;
          end
        end
        StStep: begin
          w_ftw_nxt       = r_ftw + r_ftw_step;
          w_idx_nxt       = r_idx + PT_W'(1);
          w_ftw_valid_nxt = 1'b1;
        end
        StDone: begin
          w_sweep_done_nxt = 1'b1;
          w_dac_en_nxt     = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Pll_CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_ftw         <= '0;
      r_idx         <= '0;
      r_ftw_valid   <= 1'b0;
      r_dac_en      <= 1'b0;
      r_meas_req    <= 1'b0;
      r_sweep_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_ftw         <= w_ftw_nxt;
      r_idx         <= w_idx_nxt;
      r_ftw_valid   <= w_ftw_valid_nxt;
      r_dac_en      <= w_dac_en_nxt;
      r_meas_req    <= w_meas_req_nxt;
      r_sweep_done  <= w_sweep_done_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign bus.Ftw         = r_ftw;
  assign bus.Ftw_Valid   = r_ftw_valid;
  assign bus.Dac_En      = r_dac_en;
  assign bus.Meas_Req    = r_meas_req;
  assign bus.Point_Idx   = r_idx;
  assign bus.Busy        = (r_state != StIdle);
  assign bus.Sweep_Done  = r_sweep_done;
  assign bus.Timeout_Err = r_timeout_err;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer; timeout scenario runs only with SWEEP_TIMEOUT_EN.
module tb_sweep_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  int          valid_cnt, done_cnt, done_cyc, req_first, req_cnt, err_cyc;
  int          valid_cyc[4];
  logic [31:0] valid_ftw[4];
  int          valid_idx[4];
  bit          dac_seen, ab_busy, ab_req, ab_dac;

  always #5 clk = ~clk;

  sweep_sequencer_if bus ();

  sweep_sequencer #(.TimeoutCyc(100)) dut (
    .Pll_CLK (clk),
    .RESETn  (rst_n),
    .bus     (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] fs, input logic [31:0] fst, input logic [11:0] np,
                         input logic [23:0] st);
    bus.Cfg_FtwStart = fs;
    bus.Cfg_FtwStep  = fst;
    bus.Cfg_NPoints  = np;
    bus.Cfg_Settle   = st;
  endtask

  // Start pulse at cycle 0, then observe cycles 1..ncyc; Meas_Done answers 2 cycles after Meas_Req.
  task automatic sweep_run(input int ncyc, input bit noise, input int abort_at, input bit respond);
    int req_age;
    valid_cnt = 0; done_cnt = 0; done_cyc = -1; req_first = -1; req_cnt = 0; err_cyc = -1;
    dac_seen = 0; ab_busy = 1; ab_req = 1; ab_dac = 1; req_age = 0;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (bus.Ftw_Valid) begin
        if (valid_cnt < 4) begin
          valid_cyc[valid_cnt] = c;
          valid_ftw[valid_cnt] = bus.Ftw;
          valid_idx[valid_cnt] = int'(bus.Point_Idx);
        end
        valid_cnt++;
      end
      if (bus.Sweep_Done) begin done_cnt++; done_cyc = c; end
      if (bus.Dac_En) dac_seen = 1;
      if (bus.Meas_Req) begin
        if (req_first < 0) req_first = c;
        req_cnt++;
      end
      if (bus.Timeout_Err && err_cyc < 0) err_cyc = c;
      if (abort_at != 0 && c == abort_at + 1) begin
        ab_busy = bus.Busy; ab_req = bus.Meas_Req; ab_dac = bus.Dac_En;
      end
      bus.Meas_Done = respond && bus.Meas_Req && (req_age == 2);
      req_age = bus.Meas_Req ? req_age + 1 : 0;
      if (noise) begin
        bus.Start     = (c == 3) || (c == 15);
        bus.Meas_Done = bus.Meas_Done || (c == 4) || (c == 12);
        if (c == 5) set_cfg(32'hDEAD0000, 32'h1, 12'd7, 24'd1);
      end
      bus.Abort = (c == abort_at);
      step();
    end
    bus.Start = 1'b0; bus.Abort = 1'b0; bus.Meas_Done = 1'b0;
  endtask

  task automatic check_basic(input string tag);
    check_eq({tag, "_vcnt"}, valid_cnt, 3);
    check_eq({tag, "_v0cyc"}, valid_cyc[0], 2);
    check_eq({tag, "_v1cyc"}, valid_cyc[1], 10);
    check_eq({tag, "_v2cyc"}, valid_cyc[2], 18);
    check_eq({tag, "_ftw0"}, valid_ftw[0], 32'h1000);
    check_eq({tag, "_ftw1"}, valid_ftw[1], 32'h1100);
    check_eq({tag, "_ftw2"}, valid_ftw[2], 32'h1200);
    check_eq({tag, "_idx2"}, valid_idx[2], 2);
    check_eq({tag, "_reqrise"}, req_first, 6);
    check_eq({tag, "_donecnt"}, done_cnt, 1);
    check_eq({tag, "_donecyc"}, done_cyc, 26);
    check_eq({tag, "_dacoff"}, bus.Dac_En, 0);
    check_eq({tag, "_idle"}, bus.Busy, 0);
  endtask

  initial begin
    bus.Start = 1'b0; bus.Abort = 1'b0; bus.Meas_Done = 1'b0;
    set_cfg(32'h0, 32'h0, 12'd0, 24'd0);
    step(); step();
    check_eq("rst_ftw", bus.Ftw, 0);
    check_eq("rst_valid", bus.Ftw_Valid, 0);
    check_eq("rst_dac", bus.Dac_En, 0);
    check_eq("rst_req", bus.Meas_Req, 0);
    check_eq("rst_idx", bus.Point_Idx, 0);
    check_eq("rst_busy", bus.Busy, 0);
    check_eq("rst_done", bus.Sweep_Done, 0);
    check_eq("rst_err", bus.Timeout_Err, 0);
    rst_n = 1'b1;
    step();

    set_cfg(32'h1000, 32'h100, 12'd3, 24'd4);
    sweep_run(28, 1'b0, 0, 1'b1);
    check_basic("basic");
    check_eq("basic_err", bus.Timeout_Err, 0);

    set_cfg(32'h1000, 32'h100, 12'd3, 24'd4);
    sweep_run(28, 1'b1, 0, 1'b1);
    check_basic("noise");

    set_cfg(32'hFFFFFF80, 32'h100, 12'd2, 24'd0);
    sweep_run(14, 1'b0, 0, 1'b1);
    check_eq("wrap_reqrise", req_first, 3);
    check_eq("wrap_v1cyc", valid_cyc[1], 7);
    check_eq("wrap_ftw1", valid_ftw[1], 32'h00000080);
    check_eq("wrap_donecyc", done_cyc, 12);

    set_cfg(32'h1000, 32'h100, 12'd0, 24'd4);
    sweep_run(5, 1'b0, 0, 1'b1);
    check_eq("zero_donecyc", done_cyc, 2);
    check_eq("zero_reqcnt", req_cnt, 0);
    check_eq("zero_dac", dac_seen, 0);
    check_eq("zero_vcnt", valid_cnt, 0);

    set_cfg(32'h1000, 32'h100, 12'd3, 24'd4);
    sweep_run(20, 1'b0, 15, 1'b1);
    check_eq("abort_busy", ab_busy, 0);
    check_eq("abort_req", ab_req, 0);
    check_eq("abort_dac", ab_dac, 0);
    check_eq("abort_nodone", done_cnt, 0);
    check_eq("abort_vcnt", valid_cnt, 2);
    sweep_run(28, 1'b0, 0, 1'b1);
    check_eq("restart_idx0", valid_idx[0], 0);
    check_basic("restart");

    bus.Start = 1'b1; bus.Abort = 1'b1;
    step();
    bus.Start = 1'b0; bus.Abort = 1'b0;
    check_eq("abst_busy1", bus.Busy, 0);
    step();
    check_eq("abst_busy2", bus.Busy, 0);
    check_eq("abst_valid", bus.Ftw_Valid, 0);

    sweep_run(10, 1'b0, 0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", bus.Busy, 0);
    check_eq("arst_dac", bus.Dac_En, 0);
    check_eq("arst_ftw", bus.Ftw, 0);
    check_eq("arst_idx", bus.Point_Idx, 0);
    #2 rst_n = 1'b1;
    step();

`ifdef SWEEP_TIMEOUT_EN
    set_cfg(32'h1000, 32'h100, 12'd1, 24'd4);
    sweep_run(110, 1'b0, 0, 1'b0);
    check_eq("to_reqcnt", req_cnt, 100);
    check_eq("to_errcyc", err_cyc, 106);
    check_eq("to_nodone", done_cnt, 0);
    check_eq("to_sticky", bus.Timeout_Err, 1);
    check_eq("to_idle", bus.Busy, 0);
    check_eq("to_dac", bus.Dac_En, 0);
    set_cfg(32'h1000, 32'h100, 12'd0, 24'd4);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    check_eq("to_clear", bus.Timeout_Err, 0);
    step(); step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
